mem_access_unit: RTL and testbench

//  MEM-stage load/store unit between the EX/MEM register and MEM_WB.
//  - Takes the ALU address and store data and runs one data-memory transaction per load/store.
//  - Uses a req/ack handshake to data memory.
//  - Stalls the pipeline until the transaction completes.
//  - Returns lane-extracted, sign/zero-extended load data for MEM_WB's DataMemReadData_i.

---
 rtl/mem_access_unit.sv | 162 ++++++++++++++++
 tb/tb_mem_access_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: one req/ack data-memory transaction per load/store.
// It stalls the pipeline while a transaction runs and returns extended load data.
// Optional build macro LSU_MISALIGN_TRAP_EN traps misaligned halfword/word accesses.
module mem_access_unit #(
    parameter int MAX_WAIT = 16
) (
    input  logic        sys_clk,
    input  logic        sys_start,
    input  logic        valid_i,
    input  logic        mem_read_i,
    input  logic        mem_write_i,
    input  logic [2:0]  funct3_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        stall_o,
    output logic [31:0] rdata_o,
    output logic        rdata_valid_o,
    output logic        bus_err_o,
    output logic        misalign_o,
    output logic        dmem_req_o,
    output logic        dmem_we_o,
    output logic [31:0] dmem_addr_o,
    output logic [3:0]  dmem_be_o,
    output logic [31:0] dmem_wdata_o,
    input  logic        dmem_ack_i,
    input  logic [31:0] dmem_rdata_i
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE} state_t;

    localparam int CW = (MAX_WAIT > 1) ? $clog2(MAX_WAIT) : 1;

    state_t          r_state;
    logic [1:0]      r_lane;
    logic [2:0]      r_funct3;
    logic            r_is_load;
    logic [CW-1:0]   r_wait;

    logic            w_start;
    logic            w_misalign;
    logic            w_timeout;

    assign w_start = valid_i & (mem_read_i | mem_write_i);

    // IDLE stall is combinational so EX/MEM holds on the very cycle the access is seen.
    assign stall_o = sys_start & (((r_state == S_IDLE) & w_start) | (r_state == S_REQ));

`ifdef LSU_MISALIGN_TRAP_EN
    assign w_misalign = ((funct3_i[1:0] == 2'b01) & addr_i[0]) |
                        ((funct3_i[1:0] == 2'b10) & (addr_i[1:0] != 2'b00));
`else
    assign w_misalign = 1'b0;
`endif

    generate
        if (MAX_WAIT > 0) begin : g_tmo
            assign w_timeout = (r_wait == CW'(MAX_WAIT - 1));
        end else begin : g_no_tmo
            assign w_timeout = 1'b0;
        end
    endgenerate

    function automatic logic [3:0] f_be(input logic [2:0] f3, input logic [1:0] a);
        case (f3)
            3'b000:  f_be = 4'b0001 << a;
            3'b001:  f_be = a[1] ? 4'b1100 : 4'b0011;
            default: f_be = 4'hF;
        endcase
    endfunction

    function automatic logic [31:0] f_wdata(input logic [2:0] f3, input logic [31:0] d);
        case (f3)
            3'b000:  f_wdata = {4{d[7:0]}};
            3'b001:  f_wdata = {2{d[15:0]}};
            default: f_wdata = d;
        endcase
    endfunction

    function automatic logic [31:0] f_load(input logic [2:0] f3, input logic [1:0] a,
                                           input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        b = w[{a, 3'b000} +: 8];
        h = a[1] ? w[31:16] : w[15:0];
        case (f3)
            3'b000:  f_load = {{24{b[7]}}, b};
            3'b100:  f_load = {24'd0, b};
            3'b001:  f_load = {{16{h[15]}}, h};
            3'b101:  f_load = {16'd0, h};
            default: f_load = w;
        endcase
    endfunction

    always_ff @(posedge sys_clk) begin
        if (!sys_start) begin
            r_state       <= S_IDLE;
            r_lane        <= 2'b00;
            r_funct3      <= 3'b000;
            r_is_load     <= 1'b0;
            r_wait        <= '0;
            rdata_o       <= 32'd0;
            rdata_valid_o <= 1'b0;
            bus_err_o     <= 1'b0;
            misalign_o    <= 1'b0;
            dmem_req_o    <= 1'b0;
            dmem_we_o     <= 1'b0;
            dmem_addr_o   <= 32'd0;
            dmem_be_o     <= 4'd0;
            dmem_wdata_o  <= 32'd0;
        end else begin
            rdata_valid_o <= 1'b0;
            bus_err_o     <= 1'b0;
            misalign_o    <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    rdata_o <= 32'd0;
                    if (w_start) begin
                        r_lane    <= addr_i[1:0];
                        r_funct3  <= funct3_i;
                        r_is_load <= ~mem_write_i;
                        if (w_misalign) begin
                            r_state       <= S_DONE;
                            misalign_o    <= 1'b1;
                            rdata_valid_o <= 1'b1;
                        end else begin
                            r_state      <= S_REQ;
                            r_wait       <= '0;
                            dmem_req_o   <= 1'b1;
                            dmem_we_o    <= mem_write_i;
                            dmem_addr_o  <= {addr_i[31:2], 2'b00};
                            dmem_be_o    <= mem_write_i ? f_be(funct3_i, addr_i[1:0]) : 4'hF;
                            dmem_wdata_o <= mem_write_i ? f_wdata(funct3_i, wdata_i) : 32'd0;
                        end
                    end
                end
                S_REQ: begin
                    // Ack is checked first so it wins over a coincident timeout.
                    if (dmem_ack_i || w_timeout) begin
                        r_state       <= S_DONE;
                        rdata_valid_o <= 1'b1;
                        bus_err_o     <= ~dmem_ack_i;
                        rdata_o       <= (dmem_ack_i && r_is_load) ?
                                         f_load(r_funct3, r_lane, dmem_rdata_i) : 32'd0;
                        dmem_req_o    <= 1'b0;
                        dmem_we_o     <= 1'b0;
                        dmem_addr_o   <= 32'd0;
                        dmem_be_o     <= 4'd0;
                        dmem_wdata_o  <= 32'd0;
                    end else begin
                        r_wait <= r_wait + 1'b1;
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                    rdata_o <= 32'd0;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit (MAX_WAIT=4): table of load/store vectors
// plus hand sequences for reset, idle, timeout and reset-during-request.
module tb_mem_access_unit;

    logic        sys_clk = 1'b0;
    logic        sys_start;
    logic        valid_i, mem_read_i, mem_write_i;
    logic [2:0]  funct3_i;
    logic [31:0] addr_i, wdata_i;
    logic        stall_o;
    logic [31:0] rdata_o;
    logic        rdata_valid_o, bus_err_o, misalign_o;
    logic        dmem_req_o, dmem_we_o;
    logic [31:0] dmem_addr_o;
    logic [3:0]  dmem_be_o;
    logic [31:0] dmem_wdata_o;
    logic        dmem_ack_i;
    logic [31:0] dmem_rdata_i;

    int n_pass = 0;
    int n_tot  = 0;

    always #5 sys_clk = ~sys_clk;

    mem_access_unit #(.MAX_WAIT(4)) dut (
        .sys_clk(sys_clk), .sys_start(sys_start),
        .valid_i(valid_i), .mem_read_i(mem_read_i), .mem_write_i(mem_write_i),
        .funct3_i(funct3_i), .addr_i(addr_i), .wdata_i(wdata_i),
        .stall_o(stall_o), .rdata_o(rdata_o), .rdata_valid_o(rdata_valid_o),
        .bus_err_o(bus_err_o), .misalign_o(misalign_o),
        .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
        .dmem_be_o(dmem_be_o), .dmem_wdata_o(dmem_wdata_o),
        .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i)
    );

    typedef struct {
        string       name;
        logic [2:0]  f3;
        logic        wr;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] mword;
        int          dly;
        logic [31:0] exp_addr;
        logic [31:0] exp_rd;
        logic [3:0]  exp_be;
        logic [31:0] exp_wd;
    } vec_t;

    vec_t vecs[$];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic idle_inputs();
        valid_i = 1'b0; mem_read_i = 1'b0; mem_write_i = 1'b0;
        funct3_i = 3'd0; addr_i = 32'd0; wdata_i = 32'd0;
    endtask

    task automatic do_access(input vec_t v);
        @(negedge sys_clk);
        valid_i = 1'b1; mem_read_i = ~v.wr; mem_write_i = v.wr;
        funct3_i = v.f3; addr_i = v.addr; wdata_i = v.wdata;
        #1 chk({v.name, " stall_idle"}, 32'(stall_o), 32'd1);
        chk({v.name, " req_idle"}, 32'(dmem_req_o), 32'd0);
        @(negedge sys_clk);
        for (int c = 0; c < v.dly; c++) begin
            chk({v.name, " req_wait"}, 32'(dmem_req_o), 32'd1);
            @(negedge sys_clk);
        end
        chk({v.name, " req"},   32'(dmem_req_o), 32'd1);
        chk({v.name, " stall_req"}, 32'(stall_o), 32'd1);
        chk({v.name, " we"},    32'(dmem_we_o), 32'(v.wr));
        chk({v.name, " addr"},  dmem_addr_o, v.exp_addr);
        chk({v.name, " be"},    32'(dmem_be_o), 32'(v.exp_be));
        if (v.wr) chk({v.name, " wdata"}, dmem_wdata_o, v.exp_wd);
        dmem_ack_i = 1'b1; dmem_rdata_i = v.mword;
        @(negedge sys_clk);
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
        chk({v.name, " stall_done"}, 32'(stall_o), 32'd0);
        chk({v.name, " rvalid"}, 32'(rdata_valid_o), 32'd1);
        chk({v.name, " rdata"},  rdata_o, v.exp_rd);
        chk({v.name, " buserr"}, 32'(bus_err_o), 32'd0);
        chk({v.name, " req_done"}, 32'(dmem_req_o), 32'd0);
`ifndef LSU_MISALIGN_TRAP_EN
        chk({v.name, " misalign"}, 32'(misalign_o), 32'd0);
`endif
        idle_inputs();
        @(negedge sys_clk);
        chk({v.name, " rvalid_drop"}, 32'(rdata_valid_o), 32'd0);
    endtask

    initial begin
        int reqc;
        bit seen;
        sys_start = 1'b0; dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;
        idle_inputs();

        //            name      f3    wr  addr          wdata         mword         dly exp_addr      exp_rd        be       exp_wd
        vecs.push_back('{"LW",   3'b010, 0, 32'h0000_0100, 32'h0,        32'hDEAD_BEEF, 0, 32'h0000_0100, 32'hDEAD_BEEF, 4'hF,    32'h0});
        vecs.push_back('{"LB",   3'b000, 0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 32'h0000_0100, 32'hFFFF_FF80, 4'hF,    32'h0});
        vecs.push_back('{"LBU",  3'b100, 0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 1, 32'h0000_0100, 32'h0000_0080, 4'hF,    32'h0});
        vecs.push_back('{"LH",   3'b001, 0, 32'h0000_0102, 32'h0,        32'h80FF_0000, 0, 32'h0000_0100, 32'hFFFF_80FF, 4'hF,    32'h0});
        vecs.push_back('{"LHS0", 3'b001, 0, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0, 32'h0000_0100, 32'hFFFF_F00D, 4'hF,    32'h0});
        vecs.push_back('{"LHU",  3'b101, 0, 32'h0000_0100, 32'h0,        32'h1234_F00D, 0, 32'h0000_0100, 32'h0000_F00D, 4'hF,    32'h0});
        vecs.push_back('{"LB1",  3'b000, 0, 32'h0000_0101, 32'h0,        32'h1234_F00D, 2, 32'h0000_0100, 32'hFFFF_FFF0, 4'hF,    32'h0});
        vecs.push_back('{"LD11", 3'b011, 0, 32'h0000_0000, 32'h0,        32'h1357_9BDF, 0, 32'h0000_0000, 32'h1357_9BDF, 4'hF,    32'h0});
        vecs.push_back('{"SH",   3'b001, 1, 32'h0000_0202, 32'h1234_ABCD, 32'hFFFF_FFFF, 0, 32'h0000_0200, 32'h0,        4'b1100, 32'hABCD_ABCD});
        vecs.push_back('{"SB",   3'b000, 1, 32'h0000_0301, 32'h0000_00A5, 32'hFFFF_FFFF, 1, 32'h0000_0300, 32'h0,        4'b0010, 32'hA5A5_A5A5});
        // Ack in the 4th REQ cycle coincides with the MAX_WAIT=4 timeout: ack must win.
        vecs.push_back('{"SWedge",3'b010,1, 32'h0000_0400, 32'hCAFE_F00D, 32'hFFFF_FFFF, 3, 32'h0000_0400, 32'h0,        4'hF,    32'hCAFE_F00D});
`ifndef LSU_MISALIGN_TRAP_EN
        vecs.push_back('{"LH3",  3'b001, 0, 32'h0000_0103, 32'h0,        32'h80FF_0000, 0, 32'h0000_0100, 32'hFFFF_80FF, 4'hF,    32'h0});
        vecs.push_back('{"LW5",  3'b010, 0, 32'h0000_0105, 32'h0,        32'hAABB_CCDD, 0, 32'h0000_0104, 32'hAABB_CCDD, 4'hF,    32'h0});
`endif

        repeat (2) @(posedge sys_clk);
        @(negedge sys_clk);
        chk("rst stall",  32'(stall_o), 32'd0);
        chk("rst req",    32'(dmem_req_o), 32'd0);
        chk("rst rvalid", 32'(rdata_valid_o), 32'd0);
        chk("rst rdata",  rdata_o, 32'd0);
        chk("rst be",     32'(dmem_be_o), 32'd0);
        sys_start = 1'b1;

        // No transaction when valid is low or neither read nor write.
        @(negedge sys_clk);
        valid_i = 1'b1;
        #1 chk("nop stall", 32'(stall_o), 32'd0);
        valid_i = 1'b0; mem_read_i = 1'b1;
        #1 chk("invalid stall", 32'(stall_o), 32'd0);
        @(negedge sys_clk);
        chk("invalid req", 32'(dmem_req_o), 32'd0);
        idle_inputs();

        foreach (vecs[i]) do_access(vecs[i]);

        // Timeout: ack never comes.
        @(negedge sys_clk);
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0500;
        reqc = 0; seen = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge sys_clk);
            if (bus_err_o) begin
                seen = 1'b1;
                chk("tmo stall", 32'(stall_o), 32'd0);
                chk("tmo req",   32'(dmem_req_o), 32'd0);
                chk("tmo rdata", rdata_o, 32'd0);
                break;
            end
            if (dmem_req_o) reqc++;
        end
        chk("tmo seen", 32'(seen), 32'd1);
        chk("tmo req cycles", 32'(reqc), 32'd4);
        idle_inputs();
        dmem_ack_i = 1'b1; dmem_rdata_i = 32'h1111_1111;
        @(negedge sys_clk);
        chk("tmo err pulse", 32'(bus_err_o), 32'd0);
        chk("late ack req", 32'(dmem_req_o), 32'd0);
        @(negedge sys_clk);
        chk("late ack rvalid", 32'(rdata_valid_o), 32'd0);
        chk("late ack rdata", rdata_o, 32'd0);
        dmem_ack_i = 1'b0; dmem_rdata_i = 32'd0;

        // Reset while a request is outstanding.
        @(negedge sys_clk);
        valid_i = 1'b1; mem_read_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0600;
        @(negedge sys_clk);
        chk("rreq req", 32'(dmem_req_o), 32'd1);
        sys_start = 1'b0; idle_inputs();
        @(negedge sys_clk);
        chk("rreq req after", 32'(dmem_req_o), 32'd0);
        chk("rreq stall after", 32'(stall_o), 32'd0);
        sys_start = 1'b1;
        do_access('{"LWpost", 3'b010, 0, 32'h0000_0600, 32'h0, 32'h0BAD_F00D, 0,
                    32'h0000_0600, 32'h0BAD_F00D, 4'hF, 32'h0});

`ifdef LSU_MISALIGN_TRAP_EN
        @(negedge sys_clk);
        valid_i = 1'b1; mem_write_i = 1'b1; funct3_i = 3'b010; addr_i = 32'h0000_0101;
        wdata_i = 32'h5555_5555;
        #1 chk("mis stall idle", 32'(stall_o), 32'd1);
        @(negedge sys_clk);
        chk("mis req", 32'(dmem_req_o), 32'd0);
        chk("mis we", 32'(dmem_we_o), 32'd0);
        chk("mis pulse", 32'(misalign_o), 32'd1);
        chk("mis stall done", 32'(stall_o), 32'd0);
        chk("mis rdata", rdata_o, 32'd0);
        idle_inputs();
        @(negedge sys_clk);
        chk("mis pulse drop", 32'(misalign_o), 32'd0);
        chk("mis req after", 32'(dmem_req_o), 32'd0);
`endif

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
